axi_ram_responder: RTL and testbench

AXI4 slave backed by an on-chip word-addressed RAM: the responder end of the external-memory AXI master port that the SoC exposes when built with USE_DDR. Used in simulation and on FPGA boards without DDR to stand in for external memory. It accepts single and burst reads and writes, serves one transaction at a time, and returns IDs and responses per AXI4.

---
 rtl/axi_ram_responder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_axi_ram_responder.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_responder.sv
// axi_ram_responder: AXI4 slave backed by a word-addressed on-chip RAM.
// Stands in for external memory. It handles one transaction at a time and
// accepts single-beat and burst reads and writes.
//
// Optional feature: define AXI_RAM_RANGE_CHECK_EN to enable range checking.
// Beats that fall outside the RAM return DECERR, their writes are dropped,
// and their read data is zero. Without the macro, addresses alias modulo
// the RAM depth and every response is OKAY.
//
// state  | meaning
// IDLE   | waiting for AW or AR; a write wins if both are valid together
// WDATA  | accepting W beats, one RAM write per handshake
// WRESP  | presenting the write response until bready
// RDATA  | streaming read beats from the registered RAM output
//
// Assumes AXI_ADDR_W - 2 > MEM_ADDR_W, so that upper word-address bits exist.

module axi_ram_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 14
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [AXI_ID_W-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [AXI_DATA_W-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_W/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [AXI_ID_W-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [AXI_ID_W-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [AXI_ID_W-1:0]     s_axi_rid,
    output logic [AXI_DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int WA_W   = AXI_ADDR_W - 2;
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_ADDR_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  aw_hs;
    logic                  ar_hs;
    logic                  w_hs;
    logic                  r_hs;

    // The word address is tracked at full AXI width. Its low bits index the
    // RAM, and its upper bits mark an out-of-range beat.
    logic [AXI_ID_W-1:0]   id_q;
    logic [WA_W-1:0]       addr_q;
    logic [WA_W-1:0]       addr_next;
    logic [WA_W-1:0]       rd_addr;
    logic [7:0]            beats_q;
    logic                  fixed_q;
    logic                  err_q;

    logic                  cur_hi;
    logic                  rd_hi;
    logic                  cur_oor;
    logic                  rd_oor;
    logic                  mem_we;

    logic [AXI_DATA_W-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic [AXI_DATA_W-1:0] mem [0:DEPTH-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. Readies and valids are gated by rst,
    // so they stay low for the whole time reset is held.
    always_comb begin
        state_d       = state_q;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_axi_awready = rst;
                s_axi_arready = rst && !s_axi_awvalid;
                if (s_axi_awvalid) begin
                    state_d = ST_WDATA;
                end else if (s_axi_arvalid) begin
                    state_d = ST_RDATA;
                end
            end
            ST_WDATA: begin
                s_axi_wready = rst;
                if (s_axi_wvalid && beats_q == 8'd0) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                s_axi_bvalid = rst;
                s_axi_bresp  = (rst && err_q) ? RESP_DECERR : RESP_OKAY;
                if (s_axi_bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                s_axi_rvalid = rst;
                s_axi_rlast  = rst && (beats_q == 8'd0);
                if (s_axi_rready && beats_q == 8'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    // WRAP bursts are treated as INCR; FIXED keeps the same word.
    assign addr_next = fixed_q ? addr_q : addr_q + WA_W'(1);

    // The RAM is looked up one beat ahead, so a handshake can be followed by
    // the next beat in the very next cycle.
    assign rd_addr = ar_hs ? s_axi_araddr[AXI_ADDR_W-1:2]
                   : (r_hs ? addr_next : addr_q);

    assign cur_hi = |addr_q[WA_W-1:MEM_ADDR_W];
    assign rd_hi  = |rd_addr[WA_W-1:MEM_ADDR_W];

`ifdef AXI_RAM_RANGE_CHECK_EN
    assign cur_oor = cur_hi;
    assign rd_oor  = rd_hi;
`else
    assign cur_oor = 1'b0;
    assign rd_oor  = 1'b0;
`endif

    assign mem_we = w_hs && !cur_oor;

    // Transaction context: ID, beat address, remaining-beat down-counter,
    // and the sticky write-error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_q    <= '0;
            addr_q  <= '0;
            beats_q <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (aw_hs) begin
            id_q    <= s_axi_awid;
            addr_q  <= s_axi_awaddr[AXI_ADDR_W-1:2];
            beats_q <= s_axi_awlen;
            fixed_q <= (s_axi_awburst == BURST_FIXED);
            err_q   <= 1'b0;
        end else if (ar_hs) begin
            id_q    <= s_axi_arid;
            addr_q  <= s_axi_araddr[AXI_ADDR_W-1:2];
            beats_q <= s_axi_arlen;
            fixed_q <= (s_axi_arburst == BURST_FIXED);
        end else if (w_hs) begin
            addr_q  <= addr_next;
            beats_q <= beats_q - 8'd1;
            err_q   <= err_q | cur_oor;
        end else if (r_hs) begin
            addr_q  <= addr_next;
            beats_q <= beats_q - 8'd1;
        end
    end

    // Byte-enabled RAM write port. The RAM contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[addr_q[MEM_ADDR_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port. During a stall it re-reads the same word, so
    // rdata stays stable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs || state_q == ST_RDATA) begin
            if (rd_oor) begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end else begin
                rdata_q <= mem[rd_addr[MEM_ADDR_W-1:0]];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    assign s_axi_bid   = id_q;
    assign s_axi_rid   = id_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

    // Sideband fields this responder does not interpret.
    logic unused_inputs;
`ifdef AXI_RAM_RANGE_CHECK_EN
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, s_axi_arsize, s_axi_arlock, s_axi_arcache,
                             s_axi_arprot, s_axi_arqos, s_axi_wlast,
                             s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
    assign unused_inputs = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_awqos, s_axi_arsize, s_axi_arlock, s_axi_arcache,
                             s_axi_arprot, s_axi_arqos, s_axi_wlast,
                             s_axi_awaddr[1:0], s_axi_araddr[1:0], cur_hi, rd_hi};
`endif

endmodule

// File: tb/tb_axi_ram_responder.sv
// Testbench for axi_ram_responder. It runs directed transactions and then
// randomized ones against a word-array memory model kept in this file.
// When AXI_RAM_RANGE_CHECK_EN is defined, the model applies range checking.

module tb_axi_ram_responder;

    localparam int MEM_W = 14;
    localparam int DEPTH = 1 << MEM_W;
`ifdef AXI_RAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [0:0]  s_axi_awid = '0;
    logic [23:0] s_axi_awaddr = '0;
    logic [7:0]  s_axi_awlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'b01;
    logic        s_axi_awlock = 1'b0;
    logic [3:0]  s_axi_awcache = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic [3:0]  s_axi_awqos = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [0:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [0:0]  s_axi_arid = '0;
    logic [23:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_arlock = 1'b0;
    logic [3:0]  s_axi_arcache = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic [3:0]  s_axi_arqos = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [0:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    axi_ram_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: one data word and four byte-known flags per RAM word.
    logic [31:0] m_data [DEPTH];
    logic [3:0]  m_kn   [DEPTH];

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  id;
    } r_exp_t;
    typedef struct {
        logic [0:0] id;
        logic [1:0] resp;
    } b_exp_t;

    r_exp_t r_exp[$];
    b_exp_t b_exp[$];
    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic [0:0]  got_bid;
    logic [1:0]  got_bresp;
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    function automatic int unsigned beat_word(input int unsigned start_w, input int i,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? start_w : start_w + i;
    endfunction

    function automatic bit beat_oor(input int unsigned w);
        return RANGE_EN && (w >= DEPTH);
    endfunction

    function automatic logic [31:0] kmask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic model_write(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(w % DEPTH);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                m_data[idx][8*b +: 8] = d[8*b +: 8];
                m_kn[idx][b] = 1'b1;
            end
        end
    endtask

    task automatic push_read(input logic [0:0] id, input logic [23:0] addr,
                             input logic [7:0] len, input logic [1:0] burst);
        r_exp_t e;
        int unsigned w;
        int idx;
        for (int i = 0; i <= int'(len); i++) begin
            w = beat_word(32'(addr) >> 2, i, burst);
            e.id = id;
            e.last = (i == int'(len));
            if (beat_oor(w)) begin
                e.data = 32'h0;
                e.mask = 32'hFFFF_FFFF;
                e.resp = 2'b11;
            end else begin
                idx = int'(w % DEPTH);
                e.data = m_data[idx];
                e.mask = kmask(m_kn[idx]);
                e.resp = 2'b00;
            end
            r_exp.push_back(e);
        end
    endtask

    // Checks every response handshake against the model's expectation queues.
    // It also checks that read beats hold steady while the master stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_rlast;
    always @(negedge clk) begin
        r_exp_t e;
        b_exp_t be;
        if (rst) begin
            if (prev_stall) begin
                chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
                chk("r_hold_data", s_axi_rdata, prev_rdata);
                chk("r_hold_last", 32'(s_axi_rlast), 32'(prev_rlast));
            end
            if (s_axi_rvalid && r_exp.size() == 0) begin
                chk("r_unexpected", 32'(s_axi_rvalid), 32'd0);
            end else if (s_axi_rvalid && s_axi_rready) begin
                e = r_exp.pop_front();
                chk("rdata", s_axi_rdata & e.mask, e.data & e.mask);
                chk("rresp", 32'(s_axi_rresp), 32'(e.resp));
                chk("rlast", 32'(s_axi_rlast), 32'(e.last));
                chk("rid", 32'(s_axi_rid), 32'(e.id));
            end
            if (s_axi_bvalid && b_exp.size() == 0) begin
                chk("b_unexpected", 32'(s_axi_bvalid), 32'd0);
            end else if (s_axi_bvalid && s_axi_bready) begin
                be = b_exp.pop_front();
                chk("bid", 32'(s_axi_bid), 32'(be.id));
                chk("bresp", 32'(s_axi_bresp), 32'(be.resp));
            end
            prev_stall = s_axi_rvalid && !s_axi_rready;
            prev_rdata = s_axi_rdata;
            prev_rlast = s_axi_rlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic aw_send(input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_awready && n < 50);
        chk("aw_accept", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [0:0] id, input logic [23:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
        int i = 0;
        int n = 0;
        bit err = 1'b0;
        int unsigned w;
        b_exp_t be;
        while (i <= int'(len) && n < 1000) begin
            s_axi_wvalid = ($urandom_range(3) != 0);
            s_axi_wdata = wd[i];
            s_axi_wstrb = ws[i];
            @(negedge clk);
            if (n == 0) chk("wready_after_aw", 32'(s_axi_wready), 32'd1);
            n++;
            if (s_axi_wvalid && s_axi_wready) begin
                w = beat_word(32'(addr) >> 2, i, burst);
                if (beat_oor(w)) err = 1'b1;
                else model_write(w, wd[i], ws[i]);
                i++;
            end
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        chk("w_beats", 32'(i), 32'(len) + 32'd1);
        be.id = id;
        be.resp = err ? 2'b11 : 2'b00;
        b_exp.push_back(be);
        @(negedge clk);
        chk("bvalid_latency", 32'(s_axi_bvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic b_recv();
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 200) begin
            s_axi_bready = ($urandom_range(1) == 1);
            @(negedge clk);
            n++;
            if (s_axi_bvalid && s_axi_bready) begin
                done = 1'b1;
                got_bid = s_axi_bid;
                got_bresp = s_axi_bresp;
            end
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b0;
        chk("b_done", 32'(done), 32'd1);
    endtask

    task automatic ar_send(input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        push_read(id, addr, len, burst);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axi_arready && n < 50);
        chk("ar_accept", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    // mode 0: random rready, 1: 1,0,1,0..., 2: always ready
    task automatic r_recv(input logic [7:0] len, input int mode);
        int cnt = 0;
        int n = 0;
        got_data.delete();
        got_resp.delete();
        while (cnt <= int'(len) && n < 2000) begin
            s_axi_rready = (mode == 2) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : ($urandom_range(1) == 1);
            @(negedge clk);
            if (n == 0) chk("rvalid_latency", 32'(s_axi_rvalid), 32'd1);
            n++;
            if (s_axi_rvalid && s_axi_rready) begin
                got_data.push_back(s_axi_rdata);
                got_resp.push_back(s_axi_rresp);
                cnt++;
            end
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b0;
        chk("r_beats", 32'(cnt), 32'(len) + 32'd1);
    endtask

    task automatic do_write(input logic [0:0] id, input logic [23:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        aw_send(id, addr, len, burst);
        w_send(id, addr, len, burst);
        b_recv();
        @(negedge clk);
        chk("aw_ready_after_b", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [0:0] id, input logic [23:0] addr,
                           input logic [7:0] len, input logic [1:0] burst, input int mode);
        ar_send(id, addr, len, burst);
        r_recv(len, mode);
        @(negedge clk);
        chk("ar_ready_after_r", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [0:0]  id;
        int unsigned word;
        int          sel;

        for (int i = 0; i < DEPTH; i++) begin
            m_kn[i] = 4'h0;
            m_data[i] = 32'h0;
        end

        // Reset while both address channels are requesting.
        rst = 1'b0;
        s_axi_awvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_awready", 32'(s_axi_awready), 32'd0);
            chk("rst_arready", 32'(s_axi_arready), 32'd0);
            chk("rst_wready", 32'(s_axi_wready), 32'd0);
            chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
            chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
            chk("rst_rlast", 32'(s_axi_rlast), 32'd0);
            chk("rst_ids", {30'd0, s_axi_bid, s_axi_rid}, 32'd0);
            chk("rst_resps", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
            chk("rst_rdata", s_axi_rdata, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("post_rst_arready", 32'(s_axi_arready), 32'd0);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        @(posedge clk); #1;

        // Single-beat write, then read it back.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(1'b1, 24'h10, 8'd0, 2'b01);
        chk("single_bid", 32'(got_bid), 32'd1);
        chk("single_bresp", 32'(got_bresp), 32'd0);
        do_read(1'b0, 24'h10, 8'd0, 2'b01, 2);
        chk("single_rdata", got_data[0], 32'hDEADBEEF);

        // INCR burst write, then read it back with a toggling rready.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'(i);
            ws[i] = 4'hF;
        end
        do_write(1'b0, 24'h100, 8'd3, 2'b01);
        do_read(1'b1, 24'h100, 8'd3, 2'b01, 1);
        for (int i = 0; i < 4; i++) chk("incr_rdata", got_data[i], 32'(i));

        // FIXED burst with a partial strobe on the last beat.
        wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'h1;
        do_write(1'b0, 24'h20, 8'd2, 2'b00);
        do_read(1'b0, 24'h20, 8'd0, 2'b01, 2);
        chk("fixed_merge", got_data[0], 32'h0000000C);

        // AW and AR valid together: the write goes first, and AR is accepted
        // in the cycle after the B handshake.
        s_axi_awid = 1'b1; s_axi_awaddr = 24'h40; s_axi_awlen = 8'd0; s_axi_awburst = 2'b01;
        s_axi_arid = 1'b0; s_axi_araddr = 24'h40; s_axi_arlen = 8'd0; s_axi_arburst = 2'b01;
        s_axi_awvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        chk("simul_awready", 32'(s_axi_awready), 32'd1);
        chk("simul_arready", 32'(s_axi_arready), 32'd0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        w_send(1'b1, 24'h40, 8'd0, 2'b01);
        @(negedge clk);
        chk("simul_ar_blocked", 32'(s_axi_arready), 32'd0);
        @(posedge clk); #1;
        push_read(1'b0, 24'h40, 8'd0, 2'b01);
        b_recv();
        @(negedge clk);
        chk("simul_ar_after_b", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        r_recv(8'd0, 2);
        chk("simul_rdata", got_data[0], 32'hCAFEF00D);

        // Reset in the middle of a write: the completed beat stays in RAM and
        // no response is issued.
        aw_send(1'b0, 24'h200, 8'd1, 2'b01);
        s_axi_wdata = 32'h5A5A0001; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        chk("mid_wready", 32'(s_axi_wready), 32'd1);
        model_write(32'h80, 32'h5A5A0001, 4'hF);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_wready", 32'(s_axi_wready), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        @(posedge clk); #1;
        do_read(1'b1, 24'h200, 8'd1, 2'b01, 0);
        chk("mid_rst_kept", got_data[0], 32'h5A5A0001);

        // Upper address bits: DECERR with range checking, aliasing without.
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        do_write(1'b0, 24'h0, 8'd0, 2'b01);
        do_read(1'b0, 24'h10000, 8'd0, 2'b01, 2);
        chk("range_rdata", got_data[0], RANGE_EN ? 32'h0 : 32'h12345678);
        chk("range_rresp", 32'(got_resp[0]), RANGE_EN ? 32'd3 : 32'd0);

        // Randomized transactions near the bottom, at the top wrap point and
        // above the RAM.
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(9));
            if (sel <= 6) word = $urandom_range(63);
            else if (sel <= 8) word = 32'(DEPTH - 4) + $urandom_range(3);
            else word = 32'(DEPTH) + $urandom_range(3);
            addr = 24'(word * 4 + $urandom_range(3));
            len = 8'($urandom_range(7));
            burst = 2'($urandom_range(2));
            id = 1'($urandom_range(1));
            if ($urandom_range(1) == 1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom_range(15));
                end
                do_write(id, addr, len, burst);
            end else begin
                do_read(id, addr, len, burst, 0);
            end
        end

        repeat (4) @(posedge clk);
        chk("r_exp_drained", 32'(r_exp.size()), 32'd0);
        chk("b_exp_drained", 32'(b_exp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
